cla_accum_64: RTL and testbench
===============================

CLA_ACCUM_64 -- requirements
Module: cla_accum_64

Interface
REQ-001 Params: none; operand width fixed at 64 via package constant.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin an accumulation job.
REQ-005 len  input  8  number of operands in the job; sampled when start is accepted.
REQ-006 in_valid  input  1  operand valid from upstream.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 in_data  input  64  operand.
REQ-009 sum  output  64  registered accumulated result.
REQ-010 ovf  output  1  sticky: a carry out of bit 63 occurred in the current job.
REQ-011 busy  output  1  high while a job is active, from start acceptance until done.
REQ-012 done  output  1  one-cycle pulse when the job's result is final.

Function
REQ-013 FSM states: IDLE, ACCUM, DONE.
REQ-014 IDLE: in_ready=0, busy=0; start=1 and len!=0 -> ACCUM, sum<=0, ovf<=0, cnt<=0, len latched.
REQ-015 IDLE with start=1 and len=0 -> DONE directly, sum<=0, ovf<=0.
REQ-016 ACCUM: in_ready=1, busy=1; a beat is in_valid&in_ready.
REQ-017 Each beat: sum<=CLA_64_bit(sum, in_data, cin=0).result; ovf<=ovf|cout; cnt<=cnt+1.
REQ-018 Beat with cnt==len-1 -> DONE; in_valid low -> stay in ACCUM, no state change.
REQ-019 DONE: done=1, busy=1, in_ready=0 for exactly one cycle, then IDLE.
REQ-020 Latency: sum and ovf are final in the cycle done=1, one cycle after the last beat.
REQ-021 sum and ovf hold their values in IDLE until the next accepted start.
REQ-022 start is ignored in ACCUM and DONE; no restart and no queuing.
REQ-023 Arithmetic is unsigned, modulo 2^64, unless REQ-029 applies.
REQ-024 A 256-operand job is not supported; len is at most 255.

Reset
REQ-025 rst=1 forces IDLE, sum=0, ovf=0, cnt=0, in_ready=0, busy=0, done=0 at the next edge.
REQ-026 rst takes priority over start and beats in the same cycle.
REQ-027 rst during ACCUM abandons the job; no done pulse is produced.

Configuration
REQ-028 Macro CLA_ACCUM_SAT_EN selects saturating accumulation.
REQ-029 Defined: on any beat with cout=1, or whenever ovf is already 1, sum<=64'hFFFF_FFFF_FFFF_FFFF and stays there until the job ends.
REQ-030 Undefined: sum wraps modulo 2^64; ovf is still set as in REQ-017.

Structure
REQ-031 Package cla_accum_pkg: state enum (IDLE/ACCUM/DONE), ACC_W=64, CNT_W=8, ACC_ALL_ONES.
REQ-032 The adder is the existing CLA_64_bit instantiated once; pout and gout are left unconnected.
REQ-033 No adder logic is duplicated in cla_accum_64; the adder path is combinational CLA feeding the sum register.

Verification
REQ-034 len=2; operands 0x1234567890000000, 0x00aabbccddeeff11, in_valid held high -> done 3 cycles after start, sum=0x12DF12456DEEFF11, ovf=0.
REQ-035 len=2; operands 0x5233458, 0x4578213 with one in_valid-low gap between them -> sum=0x97AB66B, done one cycle after the second beat.
REQ-036 len=2; operands 0xFFFF_FFFF_FFFF_FFFF, 0x2 -> ovf=1; sum=0x1 without the macro, sum=all-ones with CLA_ACCUM_SAT_EN.
REQ-037 start with len=0 -> done the next cycle, sum=0, and in_ready never asserted.
REQ-038 len=4; rst asserted after 2 beats -> IDLE next cycle, sum=0, no done pulse; a new job with len=1 and operand 0x7 then gives sum=0x7.
REQ-039 start pulsed during ACCUM -> ignored; cnt and sum are unaffected.

Source files
------------

// File: rtl/cla_accum_pkg.sv
// Shared types and constants for the 64-bit CLA accumulator.
package cla_accum_pkg;

  localparam int ACC_W = 64;
  localparam int CNT_W = 8;
  localparam logic [ACC_W-1:0] ACC_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cla_accum_64_cla.sv
// 64-bit carry-lookahead adder: 4-bit groups, 16-bit blocks, block-level lookahead.
module CLA_64_bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] result,
  output logic        cout,
  output logic        pout,
  output logic        gout
);

  logic [63:0] g, p, c;
  logic [15:0] gg, pg, cg;
  logic [3:0]  bg, bp, cb;

  // Carries into positions 0..3 of a 4-wide lookahead unit.
  function automatic logic [3:0] carries4(input logic [3:0] gi, input logic [3:0] pi,
                                          input logic ci);
    logic [3:0] co;
    co[0] = ci;
    co[1] = gi[0] | (pi[0] & ci);
    co[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    co[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    return co;
  endfunction

  function automatic logic group_g(input logic [3:0] gi, input logic [3:0] pi);
    return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
  endfunction

  always_comb begin
    // NOTE: every variable gets a full default before any partial write, so no latch can be inferred.
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    bg = '0;
    bp = '0;
    cg = '0;
    c  = '0;

    for (int j = 0; j < 16; j++) begin
      gg[j] = group_g(g[4*j +: 4], p[4*j +: 4]);
      pg[j] = &p[4*j +: 4];
    end
    for (int k = 0; k < 4; k++) begin
      bg[k] = group_g(gg[4*k +: 4], pg[4*k +: 4]);
      bp[k] = &pg[4*k +: 4];
    end

    cb = carries4(bg, bp, cin);
    for (int k = 0; k < 4; k++) cg[4*k +: 4] = carries4(gg[4*k +: 4], pg[4*k +: 4], cb[k]);
    for (int j = 0; j < 16; j++) c[4*j +: 4] = carries4(g[4*j +: 4], p[4*j +: 4], cg[j]);

    result = p ^ c;
    gout   = group_g(bg, bp);
    pout   = &bp;
    cout   = gout | (pout & cin);
  end

endmodule

// File: rtl/cla_accum_64.sv
// Job-based 64-bit accumulator around CLA_64_bit with a sticky carry-out flag.
// Define CLA_ACCUM_SAT_EN to saturate the sum at all-ones once a carry out occurs.
module cla_accum_64
  import cla_accum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [ACC_W-1:0] add_result;
  logic [ACC_W-1:0] next_sum;
  logic             add_cout;
  logic             beat;
  logic             pout_unused;
  logic             gout_unused;

  CLA_64_bit u_cla (
    .a      (sum),
    .b      (in_data),
    .cin    (1'b0),
    .result (add_result),
    .cout   (add_cout),
    .pout   (pout_unused),
    .gout   (gout_unused)
  );

  assign beat = in_valid & in_ready;

`ifdef CLA_ACCUM_SAT_EN
  // Once the job has overflowed the sum is pinned at all-ones until the next start.
  assign next_sum = (add_cout || ovf) ? ACC_ALL_ONES : add_result;
`else
  assign next_sum = add_result;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      sum      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      len_q    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sum   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            len_q <= len;
            busy  <= 1'b1;
            if (len != '0) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            sum <= next_sum;
            ovf <= ovf | add_cout;
            cnt <= cnt + 1'b1;
            if (cnt == len_q - 1'b1) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_accum_64.sv
// Self-checking bench for cla_accum_64 against an arithmetic job model.
module tb_cla_accum_64;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, ovf, busy, done;
  logic [7:0]  len;
  logic [63:0] in_data, sum;

  int n_vec = 0;
  int n_err = 0;
  int done_pulses = 0;
  logic [63:0] ops_q[$];

  cla_accum_64 dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .sum(sum), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Job result from unsigned 65-bit addition of the queued operands.
  function automatic void model(output logic [63:0] s, output logic o);
    logic [64:0] t;
    s = '0;
    o = 1'b0;
    foreach (ops_q[i]) begin
      t = {1'b0, s} + {1'b0, ops_q[i]};
      if (t[64]) o = 1'b1;
      s = t[63:0];
`ifdef CLA_ACCUM_SAT_EN
      if (o) s = '1;
`endif
    end
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    v = {32'($urandom), 32'($urandom)};
    if ($urandom_range(2) == 0) v[63:60] = 4'hF;
    return v;
  endfunction

  // Runs one job over ops_q; returns at the negedge one cycle after the last beat.
  task automatic run_job(input int gap_pct, input int gap_at, output int cycles, output logic got_done);
    int   idx = 0;
    int   edges = 0;
    bit   gap_used = 0;
    logic rdy;
    @(negedge clk);
    start = 1'b1; len = 8'(ops_q.size()); in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (idx < ops_q.size() && edges < 4000) begin
      rdy = in_ready;
      if ((idx == gap_at && !gap_used) || $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        if (idx == gap_at) gap_used = 1;
      end else begin
        in_valid = 1'b1;
        in_data  = ops_q[idx];
      end
      @(posedge clk);
      edges++;
      if (in_valid && rdy) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cycles   = edges + 1;
    got_done = done;
    n_vec++;
    if (idx < ops_q.size()) begin
      n_err++;
      $display("FAIL job_timeout: beats=%0d required=%0d", idx, ops_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; len = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({in_ready, busy, done, ovf} !== 4'b0000 || sum !== 64'd0) begin
      n_err++;
      $display("FAIL reset_state: rdy/busy/done/ovf=%b sum=%h required 0000 and 0",
               {in_ready, busy, done, ovf}, sum);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; logic gd;
    ops_q = '{64'h1234567890000000, 64'h00aabbccddeeff11};
    run_job(0, -1, cyc, gd);
    n_vec++;
    if (gd !== 1'b1 || cyc != 3) begin
      n_err++; $display("FAIL basic_latency: done=%b cycles=%0d required done=1 cycles=3", gd, cyc);
    end
    n_vec++;
    if (sum !== 64'h12DF12456DEEFF11 || ovf !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_result: sum=%h ovf=%b busy=%b required 12df12456deeff11 0 1", sum, ovf, busy);
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy, in_ready} !== 3'b000) begin
      n_err++; $display("FAIL basic_done_width: done/busy/rdy=%b required 000", {done, busy, in_ready});
    end
  endtask

  task automatic test_gap();
    int cyc; logic gd;
    ops_q = '{64'h5233458, 64'h4578213};
    run_job(0, 1, cyc, gd);
    n_vec++;
    if (gd !== 1'b1 || cyc != 4 || sum !== 64'h97AB66B) begin
      n_err++; $display("FAIL gap_job: done=%b cycles=%0d sum=%h required 1 4 97ab66b", gd, cyc, sum);
    end
  endtask

  task automatic test_overflow();
    int cyc; logic gd; logic [63:0] exp_s;
`ifdef CLA_ACCUM_SAT_EN
    exp_s = '1;
`else
    exp_s = 64'h1;
`endif
    ops_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
    run_job(0, -1, cyc, gd);
    n_vec++;
    if (gd !== 1'b1 || ovf !== 1'b1 || sum !== exp_s) begin
      n_err++; $display("FAIL overflow: done=%b ovf=%b sum=%h required 1 1 %h", gd, ovf, sum, exp_s);
    end
  endtask

  task automatic test_zero_len();
    logic rdy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 8'd0;
    rdy_seen |= in_ready;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rdy_seen |= in_ready;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || sum !== 64'd0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL zero_len_done: done=%b busy=%b sum=%h ovf=%b required 1 1 0 0", done, busy, sum, ovf);
    end
    @(negedge clk);
    rdy_seen |= in_ready;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || rdy_seen !== 1'b0) begin
      n_err++; $display("FAIL zero_len_after: done=%b busy=%b rdy_seen=%b required 0 0 0", done, busy, rdy_seen);
    end
  endtask

  task automatic test_abort();
    int cyc; int p; logic gd;
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = rand_op();
      @(posedge clk);
      @(negedge clk);
    end
    // A beat and a start coincide with reset; reset must win.
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 64'h55;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    p = done_pulses;
    n_vec++;
    if ({in_ready, busy, done, ovf} !== 4'b0000 || sum !== 64'd0) begin
      n_err++; $display("FAIL abort_state: rdy/busy/done/ovf=%b sum=%h required 0000 and 0",
                        {in_ready, busy, done, ovf}, sum);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (done_pulses != p || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_no_done: pulses=%0d busy=%b required %0d 0", done_pulses, busy, p);
    end
    ops_q = '{64'h7};
    run_job(0, -1, cyc, gd);
    n_vec++;
    if (gd !== 1'b1 || sum !== 64'h7) begin
      n_err++; $display("FAIL abort_next_job: done=%b sum=%h required 1 7", gd, sum);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] exp_s; logic exp_o;
    ops_q = '{rand_op(), rand_op(), rand_op()};
    model(exp_s, exp_o);
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = ops_q[0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1; len = 8'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || sum !== ops_q[0]) begin
      n_err++; $display("FAIL start_in_accum: busy=%b rdy=%b sum=%h required 1 1 %h", busy, in_ready, sum, ops_q[0]);
    end
    in_valid = 1'b1; in_data = ops_q[1];
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL start_cnt_kept: done=%b after 2 of 3 beats required 0", done);
    end
    in_data = ops_q[2];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (done !== 1'b1 || sum !== exp_s || ovf !== exp_o) begin
      n_err++; $display("FAIL start_job_result: done=%b sum=%h ovf=%b required 1 %h %b", done, sum, ovf, exp_s, exp_o);
    end
    start = 1'b1; len = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || sum !== exp_s) begin
      n_err++; $display("FAIL start_in_done: busy=%b rdy=%b sum=%h required 0 0 %h", busy, in_ready, sum, exp_s);
    end
  endtask

  task automatic test_random();
    int cyc; int n; logic gd; logic [63:0] exp_s; logic exp_o;
    for (int job = 0; job < 25; job++) begin
      n = (job == 0) ? 255 : $urandom_range(1, 12);
      ops_q = {};
      for (int i = 0; i < n; i++) ops_q.push_back(rand_op());
      model(exp_s, exp_o);
      run_job((job == 0) ? 0 : 30, -1, cyc, gd);
      n_vec++;
      if (gd !== 1'b1 || sum !== exp_s || ovf !== exp_o) begin
        n_err++; $display("FAIL random_job %0d len=%0d: done=%b sum=%h ovf=%b required 1 %h %b",
                          job, n, gd, sum, ovf, exp_s, exp_o);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      n_vec++;
      if (sum !== exp_s || ovf !== exp_o || done !== 1'b0) begin
        n_err++; $display("FAIL random_hold %0d: sum=%h ovf=%b done=%b required %h %b 0",
                          job, sum, ovf, done, exp_s, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_zero_len();
    test_abort();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
